cpu_step_enable: RTL

- Consumer end of the slow-clock path for the single-cycle RISC-V core.
- Takes a slowly toggling clock-like signal (a divider output) and a raw push-button, both asynchronous to clk.
- Converts them into single-cycle clock-enable pulses in the clk domain, so the core runs on clk, gated by cpu_en, in one of three modes: halt, free-run (one pulse per slow rising edge) or single-step (one pulse per debounced button press).

---
 rtl/cpu_step_pkg.sv | 15 +
 rtl/btn_debounce.sv | 84 ++++++++
 rtl/cpu_step_enable.sv | 97 +++++++++
 3 files changed

// File: rtl/cpu_step_pkg.sv
// Shared encodings for the CPU step-enable path: mode values and debounce states.
package cpu_step_pkg;

  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    HELD         = 2'b10,
    RELEASE_WAIT = 2'b11
  } deb_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Reusable push-button conditioner: 2-flop synchronizer, debounce FSM with a
// stability counter, registered debounced level, single-cycle press event and HELD flag.
module btn_debounce
  import cpu_step_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_evt,
  output logic held
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_s1;
  logic             btn_s;
  deb_state_t       state;
  deb_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             press_evt_next;

  // State register plus synchronizer and outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_s1    <= 1'b0;
      btn_s     <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      press_evt <= 1'b0;
      btn_level <= 1'b0;
      held      <= 1'b0;
    end else begin
      btn_s1    <= btn_raw;
      btn_s     <= btn_s1;
      state     <= state_next;
      cnt       <= cnt_next;
      press_evt <= press_evt_next;
      btn_level <= (state_next == HELD) || (state_next == RELEASE_WAIT);
      held      <= (state_next == HELD);
    end
  end

  // Counter only advances while waiting for a level to prove stable; any
  // state change leaves it at zero.
  always_comb begin
    state_next     = state;
    cnt_next       = '0;
    press_evt_next = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) state_next = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_next = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_next     = HELD;
          press_evt_next = 1'b1;
        end else begin
          cnt_next = CNT_W'(cnt + 1'b1);
        end
      end
      HELD: begin
        if (!btn_s) state_next = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_next = HELD;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE;
        end else begin
          cnt_next = CNT_W'(cnt + 1'b1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/cpu_step_enable.sv
// Turns an async slow clock and a raw step button into single-cycle cpu_en pulses
// (halt / run / step modes). Optional auto-repeat in step mode: STEP_AUTOREPEAT_EN.
module cpu_step_enable
  import cpu_step_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_CYCLES   = 25000000,
  parameter int unsigned COUNT_W         = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               slow_in,
  input  logic               step_btn,
  input  logic [1:0]         mode,
  output logic               cpu_en,
  output logic               btn_level,
  output logic [COUNT_W-1:0] pulse_count
);

  logic slow_s1;
  logic slow_s;
  logic slow_prev;
  logic slow_rise;
  logic press_evt;
  logic held;
  logic step_evt;
  logic cpu_en_next;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (step_btn),
    .btn_level(btn_level),
    .press_evt(press_evt),
    .held     (held)
  );

`ifdef STEP_AUTOREPEAT_EN
  localparam int unsigned REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_evt;

  // Repeat timer runs only while the button is held in step mode
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_cnt <= '0;
      rep_evt <= 1'b0;
    end else begin
      rep_evt <= 1'b0;
      if (held && (mode == MODE_STEP)) begin
        if (rep_cnt == REP_LAST) begin
          rep_cnt <= '0;
          rep_evt <= 1'b1;
        end else begin
          rep_cnt <= REP_W'(rep_cnt + 1'b1);
        end
      end else begin
        rep_cnt <= '0;
      end
    end
  end

  assign step_evt = press_evt | rep_evt;
`else
  logic rep_unused;
  assign rep_unused = held ^ REPEAT_CYCLES[0];
  assign step_evt   = press_evt;
`endif

  assign slow_rise = slow_s & ~slow_prev;

  // Mismatched-mode events are simply dropped; the ~cpu_en term keeps pulses isolated
  assign cpu_en_next = ~cpu_en &
                       (((mode == MODE_RUN)  && slow_rise) ||
                        ((mode == MODE_STEP) && step_evt));

  always_ff @(posedge clk) begin
    if (reset) begin
      slow_s1     <= 1'b0;
      slow_s      <= 1'b0;
      slow_prev   <= 1'b0;
      cpu_en      <= 1'b0;
      pulse_count <= '0;
    end else begin
      slow_s1   <= slow_in;
      slow_s    <= slow_s1;
      slow_prev <= slow_s;
      cpu_en    <= cpu_en_next;
      if (cpu_en_next) pulse_count <= COUNT_W'(pulse_count + 1'b1);
    end
  end

endmodule
